monitor_tx_formatter: RTL

MONITOR_TX_FORMATTER -- requirements
Module: monitor_tx_formatter

---
 rtl/monitor_tx_formatter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/monitor_tx_formatter.sv
// Monitor TX formatter: serialises echo characters, CR/LF requests and
// hex memory dumps ("aa: dd dd ..." CR LF) onto a valid/ready byte stream.
module monitor_tx_formatter #(
  parameter int LINE_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rout,
  input  logic       rout_en,
  input  logic       crlf_in,
  input  logic [7:0] write_adr_dat,
  input  logic       read_start_set,
  input  logic       read_end_set,
  input  logic       read_stop,
  output logic [7:0] mem_radr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       dump_running
);

  // state | meaning
  // IDLE  | arbitrate echo > crlf > dump
  // ECHO  | send buffered echo character
  // CR/LF | standalone line break request
  // ADRH  | address high nibble
  // ADRL  | address low nibble
  // COLON | ':' after address
  // SP    | ' ' before each data byte
  // MRD   | present address to memory
  // MCAP  | capture memory data
  // DATH  | data high nibble
  // DATL  | data low nibble
  // ECR   | end-of-line CR inside a dump
  // ELF   | end-of-line LF, then next line or finish
  typedef enum logic [3:0] {
    IDLE, ECHO, CR, LF, ADRH, ADRL, COLON, SP, MRD, MCAP, DATH, DATL, ECR, ELF
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(LINE_BYTES - 1);

  state_t     state, nxt;
  logic [7:0] echo_buf, data_reg, cur_adr, end_adr;
  logic       echo_full, crlf_pending, stop_req, done_flag;
  logic [3:0] byte_cnt;
  logic       xfer, stop_now, at_end, line_full, dump_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign xfer      = tx_valid & tx_ready;
  // A stop strobe acts in the same cycle so the in-flight character is the last data sent.
  assign stop_now  = stop_req | (read_stop & dump_running);
  // ">=" also covers end < start (single byte) and stops at 0xff without wrapping.
  assign at_end    = cur_adr >= end_adr;
  assign line_full = byte_cnt == LAST_IDX;
  assign dump_end  = (state == ELF) && xfer && (stop_now || done_flag);
  assign mem_radr  = cur_adr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; emitting states advance only on a transfer.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (echo_full)         nxt = ECHO;
        else if (crlf_pending) nxt = CR;
        else if (dump_running) nxt = stop_now ? ECR : ADRH;
      end
      ECHO:  if (xfer) nxt = IDLE;
      CR:    if (xfer) nxt = LF;
      LF:    if (xfer) nxt = IDLE;
      ADRH:  if (xfer) nxt = stop_now ? ECR : ADRL;
      ADRL:  if (xfer) nxt = stop_now ? ECR : COLON;
      COLON: if (xfer) nxt = stop_now ? ECR : SP;
      SP:    if (xfer) nxt = stop_now ? ECR : MRD;
      MRD:   nxt = stop_now ? ECR : MCAP;
      MCAP:  nxt = stop_now ? ECR : DATH;
      DATH:  if (xfer) nxt = stop_now ? ECR : DATL;
      DATL:  if (xfer) nxt = (stop_now || at_end || line_full) ? ECR : SP;
      ECR:   if (xfer) nxt = ELF;
      ELF:   if (xfer) nxt = (stop_now || done_flag) ? IDLE : ADRH;
      default: nxt = IDLE;
    endcase
  end

  // Output decode: character for the current emitting state.
  always_comb begin
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    case (state)
      ECHO:       tx_data = data_reg;
      CR, ECR:    tx_data = 8'h0d;
      LF, ELF:    tx_data = 8'h0a;
      ADRH:       tx_data = hex_ascii(cur_adr[7:4]);
      ADRL:       tx_data = hex_ascii(cur_adr[3:0]);
      COLON:      tx_data = 8'h3a;
      SP:         tx_data = 8'h20;
      DATH:       tx_data = hex_ascii(data_reg[7:4]);
      DATL:       tx_data = hex_ascii(data_reg[3:0]);
      default:    tx_valid = 1'b0;
    endcase
  end

  // Echo buffer and CR/LF request flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_buf     <= 8'h00;
      echo_full    <= 1'b0;
      crlf_pending <= 1'b0;
    end else begin
      if (rout_en && !dump_running) begin
        echo_buf  <= rout;
        echo_full <= 1'b1;
      end else if (state == IDLE && echo_full) begin
        echo_full <= 1'b0;
      end
      if (crlf_in)                   crlf_pending <= 1'b1;
      else if (state == LF && xfer)  crlf_pending <= 1'b0;
    end
  end

  // Character data register: holds the echo byte while in ECHO so a new rout_en
  // cannot disturb a presented character, and the captured memory byte in a dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             data_reg <= 8'h00;
    else if (state == IDLE && echo_full) data_reg <= echo_buf;
    else if (state == MCAP)              data_reg <= mem_rdata;
  end

  // Dump control: addresses, byte counter, running/stop/done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_adr      <= 8'h00;
      end_adr      <= 8'h00;
      byte_cnt     <= 4'h0;
      dump_running <= 1'b0;
      stop_req     <= 1'b0;
      done_flag    <= 1'b0;
    end else begin
      if (read_start_set && !dump_running)
        cur_adr <= write_adr_dat;
      else if (state == DATL && xfer && !at_end)
        cur_adr <= cur_adr + 8'h01;

      if (state == ADRH)              byte_cnt <= 4'h0;
      else if (state == DATL && xfer) byte_cnt <= byte_cnt + 4'h1;

      if (state == IDLE)                        done_flag <= 1'b0;
      else if (state == DATL && xfer && at_end) done_flag <= 1'b1;

      if (read_end_set) begin
        end_adr      <= write_adr_dat;
        dump_running <= 1'b1;
      end
      if (dump_end) begin
        dump_running <= 1'b0;
        stop_req     <= 1'b0;
      end else if (read_stop && dump_running) begin
        stop_req <= 1'b1;
      end
    end
  end

endmodule
